// File: rtl/chip8_pkg.sv
// Shared types and widths for the CHIP-8 keypad consumer block.
package chip8_pkg;

    localparam int unsigned KEY_W = 4;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        KEY_OP_TEST   = 2'd0,
        KEY_OP_WAIT   = 2'd1,
        KEY_OP_CANCEL = 2'd2,
        KEY_OP_RSVD   = 2'd3
    } key_op_t;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_RESP         = 2'd1,
        ST_WAIT_PRESS   = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } key_ctrl_state_t;

    typedef struct packed {
        logic             valid;
        logic [KEY_W-1:0] key;
    } scan_sample_t;

endpackage

// File: rtl/chip8_key_debounce.sv
// Debounces the per-scan key result: the output follows a scan value only after
// DEBOUNCE_SCANS consecutive identical scans.
module chip8_key_debounce
    import chip8_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             scan_strobe_in,
    input  logic             scan_valid_in,
    input  logic [KEY_W-1:0] scan_key_in,
    output logic             db_valid_out,
    output logic [KEY_W-1:0] db_key_out
);

    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(DEBOUNCE_SCANS);

    scan_sample_t     w_sample;
    scan_sample_t     r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_db_valid;
    logic [KEY_W-1:0] r_db_key;

    // Key number is masked when no single key is pressed so "no key" scans compare equal.
    always_comb begin
        w_sample.valid = scan_valid_in;
        w_sample.key   = scan_valid_in ? scan_key_in : '0;
        if (w_sample == r_cand) begin
            w_cnt_next = (r_cnt >= LP_MAX) ? LP_MAX : r_cnt + CNT_W'(1);
        end else begin
            w_cnt_next = CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_cand     <= '0;
            r_cnt      <= '0;
            r_db_valid <= 1'b0;
            r_db_key   <= '0;
        end else if (scan_strobe_in) begin
            r_cand <= w_sample;
            r_cnt  <= w_cnt_next;
            if (w_cnt_next == LP_MAX) begin
                r_db_valid <= w_sample.valid;
                if (w_sample.valid) begin
                    r_db_key <= w_sample.key;
                end
            end
        end
    end

    assign db_valid_out = r_db_valid;
    assign db_key_out   = r_db_key;

endmodule

// File: rtl/chip8_key_ctrl.sv
// CHIP-8 key instruction server: debounced keypad state plus TEST / WAIT / CANCEL
// request handling toward the CPU execute stage.
module chip8_key_ctrl
    import chip8_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS  = 4,
    parameter bit          WAIT_ON_RELEASE = 1'b1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             scan_strobe_in,
    input  logic             scan_valid_in,
    input  logic [KEY_W-1:0] scan_key_in,
    input  logic             req_valid_in,
    output logic             req_ready_out,
    input  logic [1:0]       req_op_in,
    input  logic [KEY_W-1:0] req_key_in,
    output logic             resp_valid_out,
    input  logic             resp_ready_in,
    output logic             resp_pressed_out,
    output logic [KEY_W-1:0] resp_key_out,
    output logic             busy_out,
    output logic             db_valid_out,
    output logic [KEY_W-1:0] db_key_out
);

    key_ctrl_state_t  r_state;
    logic             r_armed;
    logic             r_req_ready;
    logic             r_resp_valid;
    logic             r_resp_pressed;
    logic [KEY_W-1:0] r_resp_key;
    logic             r_busy;
    logic             w_db_valid;
    logic [KEY_W-1:0] w_db_key;
    key_op_t          w_op;
    logic             w_accept;
    logic             w_cancel;

    chip8_key_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .scan_strobe_in(scan_strobe_in),
        .scan_valid_in (scan_valid_in),
        .scan_key_in   (scan_key_in),
        .db_valid_out  (w_db_valid),
        .db_key_out    (w_db_key)
    );

    assign w_op     = key_op_t'(req_op_in);
    assign w_accept = req_valid_in & r_req_ready;
    assign w_cancel = req_valid_in & (w_op == KEY_OP_CANCEL);

    // Requests see the debounced state as it stands before any same-cycle scan update.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state        <= ST_IDLE;
            r_armed        <= 1'b0;
            r_req_ready    <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_resp_pressed <= 1'b0;
            r_resp_key     <= '0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        unique case (w_op)
                            KEY_OP_WAIT: begin
                                r_state     <= ST_WAIT_PRESS;
                                r_req_ready <= 1'b0;
                                r_busy      <= 1'b1;
                                r_armed     <= ~w_db_valid;
                            end
                            KEY_OP_CANCEL: begin
                                r_state <= ST_IDLE;
                            end
                            default: begin
                                r_state        <= ST_RESP;
                                r_req_ready    <= 1'b0;
                                r_resp_valid   <= 1'b1;
                                r_resp_pressed <= w_db_valid & (w_db_key == req_key_in);
                                r_resp_key     <= req_key_in;
                            end
                        endcase
                    end
                end
                // A key already held when the wait began must be released before it can count.
                ST_WAIT_PRESS: begin
                    if (w_cancel) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_armed     <= 1'b0;
                    end else if (!w_db_valid) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_resp_key     <= w_db_key;
                        r_resp_pressed <= 1'b1;
                        if (WAIT_ON_RELEASE) begin
                            r_state <= ST_WAIT_RELEASE;
                        end else begin
                            r_state      <= ST_RESP;
                            r_busy       <= 1'b0;
                            r_resp_valid <= 1'b1;
                        end
                    end
                end
                ST_WAIT_RELEASE: begin
                    if (w_cancel) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_armed     <= 1'b0;
                    end else if (!w_db_valid) begin
                        r_state      <= ST_RESP;
                        r_busy       <= 1'b0;
                        r_resp_valid <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready_in) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_armed      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_out    = r_req_ready;
    assign resp_valid_out   = r_resp_valid;
    assign resp_pressed_out = r_resp_pressed;
    assign resp_key_out     = r_resp_key;
    assign busy_out         = r_busy;
    assign db_valid_out     = w_db_valid;
    assign db_key_out       = w_db_key;

endmodule

// File: doc/chip8_key_ctrl.md
Name: chip8_key_ctrl

Overview:
- Consumer side of the CHIP-8 keypad scanner.
- Takes the per-scan key result (valid flag + key number, one strobe per completed 4-column scan) and debounces it over consecutive scans.
- Serves the CPU's key instructions over a request/response handshake: EX9E/EXA1 (test a key) and FX0A (block until a key is pressed and released).
- Sits between the keypad scanner and the CPU execute stage.

Parameters:
- DEBOUNCE_SCANS, 4: consecutive identical scan results required before the debounced state changes; legal range 1..15.
- WAIT_ON_RELEASE, 1: 1 = FX0A completes on release of the captured key; 0 = FX0A completes on debounced press.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  reset, asynchronous assert, active-low
- scan_strobe_in  input  1  one-cycle pulse: scanner finished a scan, inputs below are valid this cycle
- scan_valid_in  input  1  exactly one key pressed in this scan
- scan_key_in  input  4  key number 0x0..0xF; ignored when scan_valid_in=0
- req_valid_in  input  1  CPU request valid
- req_ready_out  output  1  block accepts a request this cycle
- req_op_in  input  2  0=TEST, 1=WAIT, 2=CANCEL, 3=reserved (treated as TEST)
- req_key_in  input  4  key tested by TEST
- resp_valid_out  output  1  response valid; held until accepted
- resp_ready_in  input  1  CPU accepts response
- resp_pressed_out  output  1  TEST: requested key is debounced-pressed; WAIT: 1
- resp_key_out  output  4  WAIT: captured key; TEST: echoes req_key_in
- busy_out  output  1  high in WAIT_PRESS or WAIT_RELEASE
- db_valid_out  output  1  debounced "one key held"
- db_key_out  output  4  debounced key (last valid value retained when db_valid_out=0)

Behaviour:
- Reset (rst_n_in low, async): all outputs 0.
  - FSM to IDLE; debounce counter 0; candidate = {valid 0, key 0}.
  - Reset mid-WAIT abandons the wait with no response.
- Debounce, evaluated only on scan_strobe_in:
  - Sample s = {scan_valid_in, scan_valid_in ? scan_key_in : 0}.
  - If s == candidate: counter saturates at DEBOUNCE_SCANS; on reaching DEBOUNCE_SCANS, db_valid_out/db_key_out take candidate the next cycle. db_key_out updates only when the valid bit is 1.
  - Otherwise: candidate <= s, counter <= 1.
  - DEBOUNCE_SCANS=1 means the state follows every scan.
- FSM states: IDLE, RESP, WAIT_PRESS, WAIT_RELEASE.
- req_ready_out = 1 only in IDLE. A request is accepted on req_valid_in & req_ready_out.
- TEST:
  - Compare uses db_valid_out & (db_key_out == req_key_in) at the accept cycle.
  - Go to RESP; resp_valid_out rises the cycle after accept (latency 1).
- WAIT:
  - Go to WAIT_PRESS; busy_out = 1.
  - A key already held at accept does not satisfy the wait. The block first requires db_valid_out=0 for at least one cycle (armed flag), then a debounced press.
  - On press, capture db_key_out. WAIT_ON_RELEASE=0: go to RESP. Otherwise go to WAIT_RELEASE.
  - WAIT_RELEASE exits to RESP when db_valid_out=0.
  - A debounced change to a different valid key during WAIT_RELEASE does not change the captured key and does not count as release.
  - Multiple keys pressed shows as db_valid_out=0 and counts as release.
- CANCEL:
  - Accepted in IDLE: no-op, no response.
  - req_ready_out is low while waiting, so cancel during a wait goes through the cancel path: in WAIT_* states, req_valid_in & req_op_in==CANCEL returns to IDLE next cycle with no response. This is the only request observed outside IDLE.
- RESP:
  - resp_valid_out = 1 with fields stable until resp_valid_out & resp_ready_in; IDLE the next cycle.
  - resp_ready_in low is allowed indefinitely; debounce continues regardless.
- Scan strobe and request in the same cycle: the request sees pre-update debounced state.
- Back-to-back: a new request is accepted no earlier than the cycle after the response handshake.

Decomposition:
- chip8_pkg: key_op_t enum (KEY_OP_TEST/WAIT/CANCEL), key_ctrl_state_t enum, KEY_W=4.
- Sub-module chip8_key_debounce: strobe-gated candidate/counter; outputs db_valid/db_key.
- Top holds the FSM and handshake.

Test Plan:
- Debounce: DEBOUNCE_SCANS=4, key 0x5 on 3 strobes then 0xA → db_valid_out stays 0. Then 0x5 on 4 strobes → db_valid_out=1, db_key_out=0x5 the cycle after the 4th strobe.
- TEST: key 0x7 debounced held; TEST 0x7 → resp_pressed_out=1, resp_key_out=0x7 one cycle after accept. TEST 0x8 → resp_pressed_out=0.
- WAIT, held-at-start case: 0x3 held when WAIT accepted → no response. Release, then press 0xC and release → resp_key_out=0xC, resp_pressed_out=1, busy_out low after handshake.
- WAIT, key swap during release: press 0x2, swap to 0x9 while in WAIT_RELEASE, release → resp_key_out=0x2.
- CANCEL and reset: CANCEL during WAIT_PRESS → IDLE, no resp_valid_out, req_ready_out=1 next cycle. rst_n_in low mid-WAIT_RELEASE → all outputs 0 immediately.
- Backpressure: resp_ready_in held 0 for 10 cycles → resp_valid_out and fields stable and req_ready_out=0; accept on cycle 11 → IDLE.
